bypass_gen: RTL and testbench

BYPASS_GEN -- requirements
Module: bypass_gen

---
 rtl/bypass_gen_pkg.sv | 37 +++
 rtl/bypass_gen_lane.sv | 99 +++++++++
 rtl/bypass_gen.sv | 42 ++++
 tb/tb_bypass_gen.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bypass_gen_pkg.sv
// Shared core types for result bypass and writeback: the bypass packet consumed by
// register-read, plus the writeback FIFO geometry.
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 4
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 64
`endif

package bypass_gen_pkg;

    localparam int ISSUE_WIDTH       = `ISSUE_WIDTH;
    localparam int SIZE_PHYSICAL_LOG = `SIZE_PHYSICAL_LOG;
    localparam int SIZE_DATA         = `SIZE_DATA;

    localparam int BYPASS_WB_DEPTH = 3;
    localparam int WB_PTR_W        = $clog2(BYPASS_WB_DEPTH);
    localparam int WB_CNT_W        = $clog2(BYPASS_WB_DEPTH + 1);

    typedef struct packed {
        logic                         valid;
        logic [SIZE_PHYSICAL_LOG-1:0] tag;
        logic [SIZE_DATA-1:0]         data;
    } bypassPkt;

    // Depth is not a power of two, so pointers wrap explicitly.
    function automatic logic [WB_PTR_W-1:0] wb_ptr_inc(input logic [WB_PTR_W-1:0] ptr);
        if (ptr == WB_PTR_W'(BYPASS_WB_DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/bypass_gen_lane.sv
// One result lane: stage-0/stage-1 bypass registers feeding a 3-entry writeback FIFO,
// with an issue credit derived purely from registered occupancy.
module bypass_gen_lane
    import bypass_gen_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         fu_valid,
    input  logic [SIZE_PHYSICAL_LOG-1:0] fu_tag,
    input  logic [SIZE_DATA-1:0]         fu_data,
    output logic                         fu_ready,
    output bypassPkt                     bypass_pkt,
    output bypassPkt                     bypass_pkt_dly,
    output logic                         wr_valid,
    output logic [SIZE_PHYSICAL_LOG-1:0] wr_tag,
    output logic [SIZE_DATA-1:0]         wr_data,
    input  logic                         wr_ready
);

    logic                         s0_valid_reg;
    logic [SIZE_PHYSICAL_LOG-1:0] s0_tag_reg;
    logic [SIZE_DATA-1:0]         s0_data_reg;
    logic                         s1_valid_reg;
    logic [SIZE_PHYSICAL_LOG-1:0] s1_tag_reg;
    logic [SIZE_DATA-1:0]         s1_data_reg;

    logic [SIZE_PHYSICAL_LOG-1:0] tag_mem  [BYPASS_WB_DEPTH];
    logic [SIZE_DATA-1:0]         data_mem [BYPASS_WB_DEPTH];
    logic [WB_PTR_W-1:0]          head_reg;
    logic [WB_PTR_W-1:0]          tail_reg;
    logic [WB_CNT_W-1:0]          count_reg;

    logic              accept;
    logic              push;
    logic              pop;
    logic [WB_CNT_W:0] credit_used;

    // The stage-0 entry already owns a FIFO slot, so it counts against the credit.
    assign credit_used = {1'b0, count_reg} + {{WB_CNT_W{1'b0}}, s0_valid_reg};
    assign fu_ready    = (credit_used <= (WB_CNT_W + 1)'(BYPASS_WB_DEPTH - 1));
    assign wr_valid    = (count_reg != '0);
    assign accept      = fu_valid && fu_ready && !flush;
    assign push        = s0_valid_reg && !flush;
    assign pop         = wr_valid && wr_ready && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0_valid_reg <= 1'b0;
            s1_valid_reg <= 1'b0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else if (flush) begin
            s0_valid_reg <= 1'b0;
            s1_valid_reg <= 1'b0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else begin
            s0_valid_reg <= accept;
            s1_valid_reg <= s0_valid_reg;
            if (push) begin
                tail_reg <= wb_ptr_inc(tail_reg);
            end
            if (pop) begin
                head_reg <= wb_ptr_inc(head_reg);
            end
            unique case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Payload storage carries no reset; only valids and pointers qualify it.
    always_ff @(posedge clk) begin
        if (accept) begin
            s0_tag_reg  <= fu_tag;
            s0_data_reg <= fu_data;
        end
        s1_tag_reg  <= s0_tag_reg;
        s1_data_reg <= s0_data_reg;
        if (push) begin
            tag_mem[tail_reg]  <= s0_tag_reg;
            data_mem[tail_reg] <= s0_data_reg;
        end
    end

    assign bypass_pkt     = '{valid: s0_valid_reg, tag: s0_tag_reg, data: s0_data_reg};
    assign bypass_pkt_dly = '{valid: s1_valid_reg, tag: s1_tag_reg, data: s1_data_reg};
    assign wr_tag         = tag_mem[head_reg];
    assign wr_data        = data_mem[head_reg];

    wb_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && (count_reg == WB_CNT_W'(BYPASS_WB_DEPTH))));

endmodule

// File: rtl/bypass_gen.sv
// Per-lane result bypass and register-file writeback; the top only replicates
// bypass_gen_lane across the issue width.
module bypass_gen
    import bypass_gen_pkg::*;
(
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           flush_i,
    input  logic [ISSUE_WIDTH-1:0]                         fuValid_i,
    input  logic [ISSUE_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]  fuTag_i,
    input  logic [ISSUE_WIDTH-1:0][SIZE_DATA-1:0]          fuData_i,
    output logic [ISSUE_WIDTH-1:0]                         fuReady_o,
    output bypassPkt [ISSUE_WIDTH-1:0]                     bypassPacket_o,
    output bypassPkt [ISSUE_WIDTH-1:0]                     bypassPacketDly_o,
    output logic [ISSUE_WIDTH-1:0]                         rfWrValid_o,
    output logic [ISSUE_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]  rfWrTag_o,
    output logic [ISSUE_WIDTH-1:0][SIZE_DATA-1:0]          rfWrData_o,
    input  logic [ISSUE_WIDTH-1:0]                         rfWrReady_i
);

    genvar gi;
    generate
        for (gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_lane
            bypass_gen_lane u_lane (
                .clk            (clk),
                .reset          (reset),
                .flush          (flush_i),
                .fu_valid       (fuValid_i[gi]),
                .fu_tag         (fuTag_i[gi]),
                .fu_data        (fuData_i[gi]),
                .fu_ready       (fuReady_o[gi]),
                .bypass_pkt     (bypassPacket_o[gi]),
                .bypass_pkt_dly (bypassPacketDly_o[gi]),
                .wr_valid       (rfWrValid_o[gi]),
                .wr_tag         (rfWrTag_o[gi]),
                .wr_data        (rfWrData_o[gi]),
                .wr_ready       (rfWrReady_i[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_bypass_gen.sv
// Self-checking bench for bypass_gen: directed scenarios plus randomized traffic
// against a queue-based model of in-flight results per lane.
module tb_bypass_gen;
    import bypass_gen_pkg::*;

    localparam int IW = ISSUE_WIDTH;
    localparam int TW = SIZE_PHYSICAL_LOG;
    localparam int DW = SIZE_DATA;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush_i = 1'b0;
    logic [IW-1:0]         fuValid_i = '0;
    logic [IW-1:0][TW-1:0] fuTag_i = '0;
    logic [IW-1:0][DW-1:0] fuData_i = '0;
    logic [IW-1:0]         fuReady_o;
    bypassPkt [IW-1:0]     bypassPacket_o;
    bypassPkt [IW-1:0]     bypassPacketDly_o;
    logic [IW-1:0]         rfWrValid_o;
    logic [IW-1:0][TW-1:0] rfWrTag_o;
    logic [IW-1:0][DW-1:0] rfWrData_o;
    logic [IW-1:0]         rfWrReady_i = '0;

    bypass_gen dut (
        .clk               (clk),
        .reset             (reset),
        .flush_i           (flush_i),
        .fuValid_i         (fuValid_i),
        .fuTag_i           (fuTag_i),
        .fuData_i          (fuData_i),
        .fuReady_o         (fuReady_o),
        .bypassPacket_o    (bypassPacket_o),
        .bypassPacketDly_o (bypassPacketDly_o),
        .rfWrValid_o       (rfWrValid_o),
        .rfWrTag_o         (rfWrTag_o),
        .rfWrData_o        (rfWrData_o),
        .rfWrReady_i       (rfWrReady_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        int            stamp;
    } entry_t;

    // Model: each lane holds accepted-but-unwritten results, stamped with acceptance cycle.
    entry_t        mq [IW][$];
    bypassPkt      exp_bp [IW];
    bypassPkt      exp_dly [IW];
    logic          exp_wr_valid [IW];
    logic [TW-1:0] exp_wr_tag [IW];
    logic [DW-1:0] exp_wr_data [IW];
    logic          exp_ready [IW];

    logic [TW-1:0] obs_acc_tag [IW][$];
    logic [TW-1:0] obs_wr_tag [IW][$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    task automatic model_clear();
        for (int l = 0; l < IW; l++) begin
            mq[l].delete();
            exp_bp[l]       = '0;
            exp_dly[l]      = '0;
            exp_wr_valid[l] = 1'b0;
            exp_wr_tag[l]   = '0;
            exp_wr_data[l]  = '0;
            exp_ready[l]    = 1'b1;
        end
    endtask

    task automatic clear_logs();
        for (int l = 0; l < IW; l++) begin
            obs_acc_tag[l].delete();
            obs_wr_tag[l].delete();
        end
    endtask

    // Advance one clock; inputs are stable from posedge+1 until the next posedge.
    task automatic step();
        logic          acc [IW];
        logic          pop [IW];
        logic [TW-1:0] tg [IW];
        logic [DW-1:0] dt [IW];
        bypassPkt      old_bp [IW];
        logic          fl;
        entry_t        e;
        fl = flush_i;
        for (int l = 0; l < IW; l++) begin
            acc[l]    = fuValid_i[l] && exp_ready[l] && !fl;
            pop[l]    = exp_wr_valid[l] && rfWrReady_i[l];
            tg[l]     = fuTag_i[l];
            dt[l]     = fuData_i[l];
            old_bp[l] = exp_bp[l];
            if (fuValid_i[l] && fuReady_o[l] && !fl) obs_acc_tag[l].push_back(fuTag_i[l]);
            if (rfWrValid_o[l] && rfWrReady_i[l]) obs_wr_tag[l].push_back(rfWrTag_o[l]);
        end
        @(posedge clk);
        cyc++;
        #1;
        for (int l = 0; l < IW; l++) begin
            if (fl) begin
                mq[l].delete();
            end else begin
                if (pop[l]) void'(mq[l].pop_front());
                if (acc[l]) begin
                    e.tag = tg[l];
                    e.data = dt[l];
                    e.stamp = cyc;
                    mq[l].push_back(e);
                end
            end
            exp_bp[l] = '0;
            if (mq[l].size() > 0) begin
                e = mq[l][mq[l].size() - 1];
                if (e.stamp == cyc) exp_bp[l] = '{valid: 1'b1, tag: e.tag, data: e.data};
            end
            exp_dly[l]      = fl ? '0 : old_bp[l];
            exp_wr_valid[l] = 1'b0;
            if (mq[l].size() > 0) begin
                e = mq[l][0];
                if (e.stamp < cyc) begin
                    exp_wr_valid[l] = 1'b1;
                    exp_wr_tag[l]   = e.tag;
                    exp_wr_data[l]  = e.data;
                end
            end
            exp_ready[l] = (mq[l].size() <= 2);
        end
    endtask

    task automatic drain();
        fuValid_i   = '0;
        flush_i     = 1'b0;
        rfWrReady_i = '1;
        repeat (5) step();
        clear_logs();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        for (int l = 0; l < IW; l++) begin
            n_checks++;
            if (bypassPacket_o[l].valid !== 1'b0 || bypassPacketDly_o[l].valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_valids lane%0d: got bp=%b dly=%b, want 0/0", l,
                         bypassPacket_o[l].valid, bypassPacketDly_o[l].valid);
            end
            n_checks++;
            if (rfWrValid_o[l] !== 1'b0 || fuReady_o[l] !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ctrl lane%0d: got wr=%b ready=%b, want 0/1", l,
                         rfWrValid_o[l], fuReady_o[l]);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        $display("test_reset done");
    endtask

    task automatic test_single();
        bypassPkt want;
        want = '{valid: 1'b1, tag: TW'('h15), data: DW'('hDEAD)};
        rfWrReady_i = '1;
        fuValid_i   = 4'b0001;
        fuTag_i[0]  = TW'('h15);
        fuData_i[0] = DW'('hDEAD);
        step();
        fuValid_i = '0;
        n_checks++;
        if (bypassPacket_o[0] !== want) begin
            n_fail++;
            $display("FAIL single_bp: got %h want %h", bypassPacket_o[0], want);
        end
        step();
        n_checks++;
        if (bypassPacketDly_o[0] !== want) begin
            n_fail++;
            $display("FAIL single_dly: got %h want %h", bypassPacketDly_o[0], want);
        end
        n_checks++;
        if (rfWrValid_o[0] !== 1'b1 || rfWrTag_o[0] !== TW'('h15) || rfWrData_o[0] !== DW'('hDEAD)) begin
            n_fail++;
            $display("FAIL single_wr: got v=%b tag=%h data=%h want 1/15/dead",
                     rfWrValid_o[0], rfWrTag_o[0], rfWrData_o[0]);
        end
        n_checks++;
        if (bypassPacket_o[0].valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_bp_oneshot: got valid=%b want 0", bypassPacket_o[0].valid);
        end
        step();
        n_checks++;
        if (rfWrValid_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_wr_done: got valid=%b want 0", rfWrValid_o[0]);
        end
        $display("test_single done");
    endtask

    task automatic test_backpressure();
        drain();
        rfWrReady_i = 4'b1101;
        for (int k = 1; k <= 8; k++) begin
            fuValid_i[1] = 1'b1;
            fuTag_i[1]   = TW'(8'h20 + k);
            fuData_i[1]  = DW'(k * 3);
            step();
            if (k >= 3) begin
                n_checks++;
                if (fuReady_o[1] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_ready_low k=%0d: got %b want 0", k, fuReady_o[1]);
                end
            end
        end
        n_checks++;
        if (obs_acc_tag[1].size() != 3) begin
            n_fail++;
            $display("FAIL bp_accept_count: got %0d want 3", obs_acc_tag[1].size());
        end
        fuValid_i[1]   = 1'b0;
        rfWrReady_i[1] = 1'b1;
        repeat (5) step();
        n_checks++;
        if (obs_wr_tag[1].size() != 3) begin
            n_fail++;
            $display("FAIL bp_write_count: got %0d want 3", obs_wr_tag[1].size());
        end
        for (int i = 0; i < 3 && i < obs_wr_tag[1].size() && i < obs_acc_tag[1].size(); i++) begin
            n_checks++;
            if (obs_wr_tag[1][i] !== obs_acc_tag[1][i]) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got %h want %h", i, obs_wr_tag[1][i], obs_acc_tag[1][i]);
            end
        end
        fuValid_i[1] = 1'b1;
        fuTag_i[1]   = TW'('h3C);
        step();
        fuValid_i[1] = 1'b0;
        n_checks++;
        if (obs_acc_tag[1].size() != 4) begin
            n_fail++;
            $display("FAIL bp_resume: got %0d accepts want 4", obs_acc_tag[1].size());
        end
        $display("test_backpressure done");
    endtask

    task automatic test_throughput();
        drain();
        for (int k = 0; k < 20; k++) begin
            fuValid_i = '1;
            for (int l = 0; l < IW; l++) begin
                fuTag_i[l]  = TW'($urandom);
                fuData_i[l] = {$urandom, $urandom};
            end
            step();
            n_checks++;
            if (fuReady_o !== '1) begin
                n_fail++;
                $display("FAIL tput_ready k=%0d: got %b want all 1", k, fuReady_o);
            end
            for (int l = 0; l < IW; l++) begin
                n_checks++;
                if (rfWrValid_o[l] !== exp_wr_valid[l] ||
                    (exp_wr_valid[l] && (rfWrTag_o[l] !== exp_wr_tag[l] || rfWrData_o[l] !== exp_wr_data[l]))) begin
                    n_fail++;
                    $display("FAIL tput_wr lane%0d k=%0d: got %b/%h want %b/%h", l, k,
                             rfWrValid_o[l], rfWrTag_o[l], exp_wr_valid[l], exp_wr_tag[l]);
                end
            end
        end
        fuValid_i = '0;
        repeat (4) step();
        for (int l = 0; l < IW; l++) begin
            n_checks++;
            if (obs_acc_tag[l].size() != 20 || obs_wr_tag[l].size() != 20) begin
                n_fail++;
                $display("FAIL tput_counts lane%0d: got acc=%0d wr=%0d want 20/20", l,
                         obs_acc_tag[l].size(), obs_wr_tag[l].size());
            end
        end
        $display("test_throughput done");
    endtask

    task automatic test_flush();
        drain();
        rfWrReady_i = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            fuValid_i[2] = 1'b1;
            fuTag_i[2]   = TW'(8'h40 + k);
            step();
        end
        flush_i    = 1'b1;
        fuTag_i[2] = TW'('h7F);
        step();
        flush_i   = 1'b0;
        fuValid_i = '0;
        for (int l = 0; l < IW; l++) begin
            n_checks++;
            if (bypassPacket_o[l].valid !== 1'b0 || bypassPacketDly_o[l].valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_valids lane%0d: got %b/%b want 0/0", l,
                         bypassPacket_o[l].valid, bypassPacketDly_o[l].valid);
            end
        end
        n_checks++;
        if (rfWrValid_o[2] !== 1'b0 || fuReady_o[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_lane2: got wr=%b ready=%b want 0/1", rfWrValid_o[2], fuReady_o[2]);
        end
        rfWrReady_i = '1;
        repeat (4) step();
        n_checks++;
        if (obs_wr_tag[2].size() != 0) begin
            n_fail++;
            $display("FAIL flush_no_write: got %0d writes want 0", obs_wr_tag[2].size());
        end
        $display("test_flush done");
    endtask

    task automatic test_async_reset();
        drain();
        rfWrReady_i = '0;
        for (int k = 0; k < 2; k++) begin
            fuValid_i = '1;
            for (int l = 0; l < IW; l++) fuTag_i[l] = TW'($urandom);
            step();
        end
        n_checks++;
        if (bypassPacket_o[0].valid !== exp_bp[0].valid) begin
            n_fail++;
            $display("FAIL areset_busy: got bp0 valid=%b want %b", bypassPacket_o[0].valid, exp_bp[0].valid);
        end
        #3;
        reset = 1'b0;
        #1;
        for (int l = 0; l < IW; l++) begin
            n_checks++;
            if (bypassPacket_o[l].valid !== 1'b0 || bypassPacketDly_o[l].valid !== 1'b0 ||
                rfWrValid_o[l] !== 1'b0 || fuReady_o[l] !== 1'b1) begin
                n_fail++;
                $display("FAIL areset_lane%0d: got bp=%b dly=%b wr=%b rdy=%b want 0/0/0/1", l,
                         bypassPacket_o[l].valid, bypassPacketDly_o[l].valid, rfWrValid_o[l], fuReady_o[l]);
            end
        end
        fuValid_i = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        $display("test_async_reset done");
    endtask

    task automatic test_wrap();
        drain();
        rfWrReady_i = 4'b0111;
        for (int k = 0; k < 15; k++) begin
            if (k == 3) rfWrReady_i[3] = 1'b1;
            fuValid_i[3] = 1'b1;
            fuTag_i[3]   = TW'(8'h50 + k);
            fuData_i[3]  = {$urandom, $urandom};
            step();
            n_checks++;
            if (rfWrValid_o[3] !== exp_wr_valid[3] || fuReady_o[3] !== exp_ready[3] ||
                (exp_wr_valid[3] && rfWrTag_o[3] !== exp_wr_tag[3])) begin
                n_fail++;
                $display("FAIL wrap k=%0d: got wr=%b tag=%h rdy=%b want %b/%h/%b", k,
                         rfWrValid_o[3], rfWrTag_o[3], fuReady_o[3], exp_wr_valid[3], exp_wr_tag[3], exp_ready[3]);
            end
        end
        fuValid_i[3] = 1'b0;
        repeat (5) step();
        n_checks++;
        if (obs_wr_tag[3].size() != obs_acc_tag[3].size()) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d writes want %0d", obs_wr_tag[3].size(), obs_acc_tag[3].size());
        end
        for (int i = 0; i < obs_wr_tag[3].size() && i < obs_acc_tag[3].size(); i++) begin
            n_checks++;
            if (obs_wr_tag[3][i] !== obs_acc_tag[3][i]) begin
                n_fail++;
                $display("FAIL wrap_order[%0d]: got %h want %h", i, obs_wr_tag[3][i], obs_acc_tag[3][i]);
            end
        end
        $display("test_wrap done");
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            for (int l = 0; l < IW; l++) begin
                fuValid_i[l]   = ($urandom_range(0, 9) < 7);
                rfWrReady_i[l] = ($urandom_range(0, 9) < 6);
                fuTag_i[l]     = TW'($urandom);
                fuData_i[l]    = {$urandom, $urandom};
            end
            flush_i = ($urandom_range(0, 99) < 3);
            step();
            for (int l = 0; l < IW; l++) begin
                n_checks++;
                if (fuReady_o[l] !== exp_ready[l] ||
                    bypassPacket_o[l].valid !== exp_bp[l].valid ||
                    (exp_bp[l].valid && bypassPacket_o[l] !== exp_bp[l]) ||
                    bypassPacketDly_o[l].valid !== exp_dly[l].valid ||
                    (exp_dly[l].valid && bypassPacketDly_o[l] !== exp_dly[l]) ||
                    rfWrValid_o[l] !== exp_wr_valid[l] ||
                    (exp_wr_valid[l] && (rfWrTag_o[l] !== exp_wr_tag[l] || rfWrData_o[l] !== exp_wr_data[l]))) begin
                    n_fail++;
                    $display("FAIL random lane%0d k=%0d: got rdy=%b bp=%h dly=%h wr=%b/%h; want rdy=%b bp=%h dly=%h wr=%b/%h",
                             l, k, fuReady_o[l], bypassPacket_o[l], bypassPacketDly_o[l], rfWrValid_o[l], rfWrTag_o[l],
                             exp_ready[l], exp_bp[l], exp_dly[l], exp_wr_valid[l], exp_wr_tag[l]);
                end
            end
        end
        flush_i = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        model_clear();
        clear_logs();
        test_reset();
        test_single();
        test_backpressure();
        test_throughput();
        test_flush();
        test_async_reset();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
